// File: rtl/suma_c2.sv
// Registered two's-complement adder: s/coutfin <= a + b + ci, one cycle latency.
// Define SUMA_C2_OVF_EN to add the registered signed-overflow output ovf.
module suma_c2 #(
  parameter int ANCHO = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic             ci,
  output logic [ANCHO-1:0] s,
  output logic             coutfin,
`ifdef SUMA_C2_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [ANCHO:0]   c;
  logic [ANCHO-1:0] sum_w;

  // Ripple chain of 1-bit full adders; kept in one process so the carry
  // vector is not split across combinational blocks.
  always_comb begin
    c     = '0;
    sum_w = '0;
    c[0]  = ci;
    for (int i = 0; i < ANCHO; i++) begin
      c[i+1]   = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
      sum_w[i] = a[i] ^ b[i] ^ c[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      coutfin   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s       <= sum_w;
        coutfin <= c[ANCHO];
      end
    end
  end

`ifdef SUMA_C2_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= c[ANCHO] ^ c[ANCHO-1];
    end
  end
`endif

endmodule

// File: tb/tb_suma_c2.sv
// Scoreboard bench for suma_c2: driver pushes expected register contents per
// cycle, monitor pops and compares after each rising edge.
module tb_suma_c2;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         ci;
  logic [W-1:0] s;
  logic         coutfin;
  logic         out_valid;
`ifdef SUMA_C2_OVF_EN
  logic         ovf;
`endif

  suma_c2 #(.ANCHO(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .s         (s),
    .coutfin   (coutfin),
`ifdef SUMA_C2_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: what the output registers should hold.
  logic [W-1:0] m_s = '0;
  logic         m_c = 1'b0;
  logic         m_o = 1'b0;

  task automatic drive(input logic r, input logic v, input logic [W-1:0] ta,
                       input logic [W-1:0] tb, input logic tci);
    logic [W:0] full;
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; a = ta; b = tb; ci = tci;
    if (r) begin
      m_s = '0; m_c = 1'b0; m_o = 1'b0;
    end else if (v) begin
      full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tci};
      m_s  = full[W-1:0];
      m_c  = full[W];
      m_o  = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
    end
    e.v = v && !r; e.s = m_s; e.c = m_c; e.o = m_o;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (out_valid !== e.v) begin
        errors++;
        $display("FAIL out_valid: got %b want %b", out_valid, e.v);
      end
      checks++;
      if (s !== e.s) begin
        errors++;
        $display("FAIL sum: got %h want %h", s, e.s);
      end
      checks++;
      if (coutfin !== e.c) begin
        errors++;
        $display("FAIL coutfin: got %b want %b", coutfin, e.c);
      end
`ifdef SUMA_C2_OVF_EN
      checks++;
      if (ovf !== e.o) begin
        errors++;
        $display("FAIL ovf: got %b want %b", ovf, e.o);
      end
`endif
    end
  end

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: r = '1;
      1: r = '0;
      2: r = {1'b1, {(W-1){1'b0}}};
      3: r = {1'b0, {(W-1){1'b1}}};
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [W-1:0] ones, one, minv, maxv;
    int wait_cyc;
    ones = '1; one = W'(1); minv = {1'b1, {(W-1){1'b0}}}; maxv = ~minv;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0;

    drive(1, 1, W'(5), W'(7), 0);
    drive(1, 1, W'(5), W'(7), 0);
    drive(0, 1, ones, one, 0);
    drive(0, 1, one, ones, 0);
    drive(0, 1, minv, minv, 0);
    drive(0, 1, maxv, one, 0);
    drive(0, 1, '0, '0, 1);
    drive(0, 0, W'(3), W'(9), 1);
    drive(0, 0, W'(11), W'(2), 0);
    drive(0, 0, ones, ones, 1);
    drive(0, 1, W'(100), W'(23), 1);
    drive(1, 1, W'(5), W'(7), 0);
    drive(0, 1, W'(5), W'(7), 0);
    drive(0, 1, ones, '0, 1);

    for (int i = 0; i < 1000; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
    end
    drive(0, 0, '0, '0, 0);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
